// File: rtl/router_pkg.sv
// Shared router definitions: read_en port ordering, default flit width and
// the idle/one-hot grant encodings used by the output arbiters.
package router_pkg;

  // Bit positions of the per-output-port grants in read_en
  localparam int unsigned PORT_N = 0;
  localparam int unsigned PORT_E = 1;
  localparam int unsigned PORT_W = 2;
  localparam int unsigned PORT_S = 3;
  localparam int unsigned PORT_L = 4;
  localparam int unsigned NUM_PORTS = 5;

  // Default flit width
  localparam int unsigned FLIT_WIDTH = 32;

  // Arbiter grant states: idle or one-hot in read_en bit order
  typedef enum logic [NUM_PORTS-1:0] {
    ARB_IDLE  = 5'b00000,
    ARB_GNT_N = 5'b00001,
    ARB_GNT_E = 5'b00010,
    ARB_GNT_W = 5'b00100,
    ARB_GNT_S = 5'b01000,
    ARB_GNT_L = 5'b10000
  } arb_state_e;

endpackage : router_pkg

// File: rtl/rx_fifo_mem.sv
// DEPTH x DATA_WIDTH register file for the receive FIFO. One-hot write
// select, one-hot read mux, storage intentionally not reset.
module rx_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH-1:0]      wr_sel,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DEPTH-1:0]      rd_sel,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  // Next storage contents: only the selected slot takes wr_data
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_en && wr_sel[i]) begin
        mem_d[i] = wr_data;
      end
    end
  end

  // Storage registers, no reset
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // One-hot read mux (AND-OR)
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rd_sel[i]) begin
        rd_data = rd_data | mem_q[i];
      end
    end
  end

endmodule : rx_fifo_mem

// File: rtl/handshake_rx_fifo.sv
// Router input-port receiver: RTS/DCTS handshake with the upstream router,
// DEPTH-entry FIFO with one-hot pointers, pop on any downstream grant.
// Optional feature macro: RX_FIFO_OCCUPANCY_EN adds the occupancy output.
module handshake_rx_fifo
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FLIT_WIDTH,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         RX,
  input  logic                          RTS,
  output logic                          DCTS,
  input  logic [NUM_PORTS-1:0]          read_en,
  output logic [DATA_WIDTH-1:0]         Data_out,
  output logic                          empty,
  output logic                          full
`ifdef RX_FIFO_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             dcts_q,   dcts_d;
  logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign DCTS  = dcts_q;

`ifdef RX_FIFO_OCCUPANCY_EN
  assign occupancy = count_q;
`endif

  // Handshake, pointer rotation and occupancy bookkeeping
  always_comb begin
    // ~dcts_q keeps DCTS from staying high, so a write can never overflow
    dcts_d   = RTS & ~dcts_q & ~full;
    wr_en    = dcts_q & RTS;
    rd_en    = (|read_en) & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = {wr_ptr_q[DEPTH-2:0], wr_ptr_q[DEPTH-1]};
    end
    if (rd_en) begin
      rd_ptr_d = {rd_ptr_q[DEPTH-2:0], rd_ptr_q[DEPTH-1]};
    end
    if (wr_en && !rd_en) begin
      count_d = count_q + CW'(1);
    end else if (rd_en && !wr_en) begin
      count_d = count_q - CW'(1);
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      dcts_q   <= 1'b0;
      wr_ptr_q <= DEPTH'(1);
      rd_ptr_q <= DEPTH'(1);
      count_q  <= '0;
    end else begin
      dcts_q   <= dcts_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  rx_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_sel  (wr_ptr_q),
    .wr_data (RX),
    .rd_sel  (rd_ptr_q),
    .rd_data (Data_out)
  );

endmodule : handshake_rx_fifo

// File: tb/tb_handshake_rx_fifo.sv
// Bench for handshake_rx_fifo: directed scenarios plus randomized traffic,
// checked against a queue-based reference model.
module tb_handshake_rx_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] RX;
  logic          RTS;
  logic          DCTS;
  logic [4:0]    read_en;
  logic [DW-1:0] Data_out;
  logic          empty;
  logic          full;
`ifdef RX_FIFO_OCCUPANCY_EN
  logic [CW-1:0] occupancy;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  handshake_rx_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .RX       (RX),
    .RTS      (RTS),
    .DCTS     (DCTS),
    .read_en  (read_en),
    .Data_out (Data_out),
    .empty    (empty),
    .full     (full)
`ifdef RX_FIFO_OCCUPANCY_EN
    ,
    .occupancy (occupancy)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored flits plus the clear-to-send bit
  logic    m_dcts = 1'b0;
  logic [DW-1:0] m_q[$];

  always @(posedge clk) begin
    logic wr, rd, m_full, nd;
    if (rst) begin
      m_dcts = 1'b0;
      m_q.delete();
    end else begin
      m_full = (m_q.size() == DEPTH);
      wr = m_dcts && RTS;
      rd = (read_en != 5'b0) && (m_q.size() != 0);
      nd = RTS && !m_dcts && !m_full;
      if (rd) void'(m_q.pop_front());
      if (wr) m_q.push_back(RX);
      m_dcts = nd;
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold RTS with data until DCTS is seen, then let the write edge pass
  task automatic send_flit(input logic [DW-1:0] d);
    int waited = 0;
    RTS = 1'b1;
    RX  = d;
    cycle();
    while (!DCTS && waited < 20) begin
      cycle();
      waited++;
    end
    n_checks++;
    if (DCTS !== 1'b1) $display("FAIL send_dcts_timeout data=%h DCTS=%b required=1", d, DCTS);
    else n_pass++;
    cycle();
    RTS = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; RTS = 1'b0; RX = '0; read_en = '0;
    cycle(); cycle();
    n_checks++;
    if ({DCTS, empty, full} !== 3'b010) $display("FAIL reset_flags DCTS/empty/full=%b%b%b required=010", DCTS, empty, full);
    else n_pass++;
`ifdef RX_FIFO_OCCUPANCY_EN
    n_checks++;
    if (occupancy !== '0) $display("FAIL reset_occupancy got=%0d required=0", occupancy);
    else n_pass++;
`endif
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++;
      if ({DCTS, empty, full} !== 3'b010) $display("FAIL idle_flags cyc=%0d got=%b%b%b required=010", i, DCTS, empty, full);
      else n_pass++;
    end
  endtask

  task automatic test_single_flit();
    RTS = 1'b1; RX = 32'hA5A5_0001;
    cycle();
    n_checks++;
    if (DCTS !== 1'b1 || empty !== 1'b1) $display("FAIL single_dcts DCTS=%b empty=%b required DCTS=1 empty=1", DCTS, empty);
    else n_pass++;
    cycle();
    RTS = 1'b0;
    n_checks++;
    if (empty !== 1'b0 || Data_out !== 32'hA5A5_0001 || DCTS !== 1'b0)
      $display("FAIL single_data empty=%b Data_out=%h DCTS=%b required 0/a5a50001/0", empty, Data_out, DCTS);
    else n_pass++;
    read_en = 5'b00010;
    cycle();
    read_en = '0;
    n_checks++;
    if (empty !== 1'b1) $display("FAIL single_pop empty=%b required=1", empty);
    else n_pass++;
  endtask

  task automatic test_fill();
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send_flit(DW'(i));
      n_checks++;
      if (full !== (i == 4)) $display("FAIL fill_full after=%0d full=%b required=%b", i, full, (i == 4));
      else n_pass++;
    end
    RTS = 1'b1; RX = 32'hDEAD_BEEF;
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_checks++;
      if (DCTS !== 1'b0 || full !== 1'b1) $display("FAIL fill_hold cyc=%0d DCTS=%b full=%b required 0/1", i, DCTS, full);
      else n_pass++;
    end
`ifdef RX_FIFO_OCCUPANCY_EN
    n_checks++;
    if (occupancy !== CW'(4)) $display("FAIL fill_occupancy got=%0d required=4", occupancy);
    else n_pass++;
`endif
    RTS = 1'b0;
  endtask

  task automatic test_drain_wrap();
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (Data_out !== DW'(i) || empty !== 1'b0) $display("FAIL drain_head idx=%0d Data_out=%h empty=%b required %h/0", i, Data_out, empty, DW'(i));
      else n_pass++;
      read_en = 5'b00100;
      cycle();
    end
    read_en = '0;
    n_checks++;
    if (empty !== 1'b1 || full !== 1'b0) $display("FAIL drain_empty empty=%b full=%b required 1/0", empty, full);
    else n_pass++;
    send_flit(32'h5);
    n_checks++;
    if (Data_out !== 32'h5 || empty !== 1'b0) $display("FAIL wrap_head Data_out=%h empty=%b required 00000005/0", Data_out, empty);
    else n_pass++;
  endtask

  task automatic test_concurrent();
    int pops;
    send_flit(32'h6);
    RTS = 1'b1; RX = 32'h7;
    cycle();
    n_checks++;
    if (DCTS !== 1'b1) $display("FAIL conc_dcts DCTS=%b required=1", DCTS);
    else n_pass++;
    read_en = 5'b10000;
    cycle();
    RTS = 1'b0; read_en = '0;
    n_checks++;
    if (Data_out !== 32'h6 || empty !== 1'b0 || full !== 1'b0) $display("FAIL conc_head Data_out=%h empty=%b full=%b required 00000006/0/0", Data_out, empty, full);
    else n_pass++;
`ifdef RX_FIFO_OCCUPANCY_EN
    n_checks++;
    if (occupancy !== CW'(2)) $display("FAIL conc_occupancy got=%0d required=2", occupancy);
    else n_pass++;
`endif
    read_en = 5'b11111;
    cycle();
    read_en = '0;
    n_checks++;
    if (Data_out !== 32'h7 || empty !== 1'b0) $display("FAIL multi_pop Data_out=%h empty=%b required 00000007/0", Data_out, empty);
    else n_pass++;
    pops = 0;
    while (!empty && pops < 10) begin
      read_en = 5'b01000;
      cycle();
      pops++;
    end
    read_en = '0;
    n_checks++;
    if (pops != 1) $display("FAIL conc_remaining pops=%0d required=1", pops);
    else n_pass++;
  endtask

  task automatic test_empty_pop_reset();
    read_en = 5'b00001;
    cycle(); cycle();
    read_en = '0;
    n_checks++;
    if (empty !== 1'b1) $display("FAIL empty_pop empty=%b required=1", empty);
    else n_pass++;
    send_flit(32'h8);
    n_checks++;
    if (Data_out !== 32'h8) $display("FAIL empty_pop_ptr Data_out=%h required=00000008", Data_out);
    else n_pass++;
    send_flit(32'h9);
    send_flit(32'hA);
    RTS = 1'b1; RX = 32'hB;
    cycle();
    n_checks++;
    if (DCTS !== 1'b1) $display("FAIL midreset_pre DCTS=%b required=1", DCTS);
    else n_pass++;
    rst = 1'b1;
    cycle();
    rst = 1'b0; RTS = 1'b0;
    n_checks++;
    if ({DCTS, empty, full} !== 3'b010) $display("FAIL midreset_flags DCTS/empty/full=%b%b%b required=010", DCTS, empty, full);
    else n_pass++;
`ifdef RX_FIFO_OCCUPANCY_EN
    n_checks++;
    if (occupancy !== '0) $display("FAIL midreset_occupancy got=%0d required=0", occupancy);
    else n_pass++;
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      RTS     = ($urandom_range(0, 3) != 0);
      RX      = $urandom;
      read_en = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0;
      cycle();
      n_checks++;
      if (DCTS !== m_dcts || empty !== (m_q.size() == 0) || full !== (m_q.size() == DEPTH))
        $display("FAIL rand_flags cyc=%0d DCTS/empty/full=%b%b%b required=%b%b%b", i, DCTS, empty, full,
                 m_dcts, (m_q.size() == 0), (m_q.size() == DEPTH));
      else n_pass++;
      if (m_q.size() != 0) begin
        n_checks++;
        if (Data_out !== m_q[0]) $display("FAIL rand_head cyc=%0d Data_out=%h required=%h", i, Data_out, m_q[0]);
        else n_pass++;
      end
`ifdef RX_FIFO_OCCUPANCY_EN
      n_checks++;
      if (occupancy !== CW'(m_q.size())) $display("FAIL rand_occupancy cyc=%0d got=%0d required=%0d", i, occupancy, m_q.size());
      else n_pass++;
`endif
    end
    rst = 1'b0; RTS = 1'b0; read_en = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; RTS = 1'b0; RX = '0; read_en = '0;
    @(negedge clk);
    test_reset();
    test_single_flit();
    test_fill();
    test_drain_wrap();
    test_concurrent();
    test_empty_pop_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_handshake_rx_fifo
